// File: rtl/usb_fifo_byte_reader_if.sv
// Register-bus and FIFO-port bundle for usb_fifo_byte_reader.
// master = USB register interface / FIFO side, slave = the byte reader.
interface usb_fifo_byte_reader_if #(
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic                     reg_read;
  logic                     reg_write;
  logic [7:0]               reg_datao;
  logic [7:0]               reg_datai;
  logic                     fast_fifo_read;
  logic [31:0]              fifo_dout;
  logic                     fifo_empty;
  logic                     fifo_rd_en;
  logic                     fifo_underflow;

  modport master (
    output reg_address, reg_bytecnt, reg_read, reg_write, reg_datao,
    output fifo_dout, fifo_empty,
    input  reg_datai, fast_fifo_read, fifo_rd_en, fifo_underflow
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_read, reg_write, reg_datao,
    input  fifo_dout, fifo_empty,
    output reg_datai, fast_fifo_read, fifo_rd_en, fifo_underflow
  );
endinterface

// File: rtl/usb_fifo_byte_reader.sv
// Serves a 32-bit FWFT FIFO byte-wise on the USB register bus, with status/control register.
// Optional macro USB_FIFO_RD_STATS_EN adds a 16-bit popped-word counter in status bytes 1-2.
module usb_fifo_byte_reader #(
  parameter logic [7:0] pFIFO_ADDR   = 8'h03,
  parameter logic [7:0] pSTATUS_ADDR = 8'h04
) (
  input logic                   clk_usb,
  input logic                   reset,
  usb_fifo_byte_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, STREAM = 2'd2} state_t;

  state_t     state;
  logic [1:0] idx;
  logic       fifo_sel;
  logic       status_sel;
  logic       rd_end;
  logic       pop_hit;
  logic       status_wr;
  logic       clear_req;
  logic       reg_read_r;
  logic       mode;
  logic       underflow;
  logic       rd_en;
  logic       fast;
  logic [7:0] datai;
  logic [7:0] datai_next;
  logic [7:0] fifo_byte;
  logic [7:0] status_byte;
  logic [7:0] count_lo;
  logic [7:0] count_hi;
  logic       unused_bits;

  assign idx        = bus.reg_bytecnt[1:0];
  assign fifo_sel   = (bus.reg_address == pFIFO_ADDR);
  assign status_sel = (bus.reg_address == pSTATUS_ADDR);
  // Upstream bumps bytecnt on this same edge, so idx still names the byte just read.
  assign rd_end     = reg_read_r & ~bus.reg_read;
  assign pop_hit    = rd_end & fifo_sel & (idx == 2'd3);
  assign status_wr  = bus.reg_write & status_sel & (idx == 2'd0);
  assign clear_req  = status_wr & bus.reg_datao[0];

  assign unused_bits = ^{bus.reg_datao[7:2], bus.reg_bytecnt};

`ifdef USB_FIFO_RD_STATS_EN
  logic [15:0] word_count;

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset)
      word_count <= 16'h0000;
    else if (clear_req)
      word_count <= 16'h0000;
    else if (rd_en)
      word_count <= word_count + 16'd1;
  end

  assign count_lo = word_count[7:0];
  assign count_hi = word_count[15:8];
`else
  assign count_lo = 8'h00;
  assign count_hi = 8'h00;
`endif

  always_comb begin
    fifo_byte   = 8'h00;
    status_byte = 8'h00;
    case (idx)
      2'd0: begin
        fifo_byte   = bus.fifo_dout[7:0];
        status_byte = {5'b00000, mode, underflow, bus.fifo_empty};
      end
      2'd1: begin
        fifo_byte   = bus.fifo_dout[15:8];
        status_byte = count_lo;
      end
      2'd2: begin
        fifo_byte   = bus.fifo_dout[23:16];
        status_byte = count_hi;
      end
      default: begin
        fifo_byte   = bus.fifo_dout[31:24];
        status_byte = 8'h00;
      end
    endcase
  end

  always_comb begin
    datai_next = 8'h00;
    if (fifo_sel)
      datai_next = bus.fifo_empty ? 8'h00 : fifo_byte;
    else if (status_sel)
      datai_next = status_byte;
  end

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      reg_read_r <= 1'b0;
      datai      <= 8'h00;
      rd_en      <= 1'b0;
      underflow  <= 1'b0;
      mode       <= 1'b0;
    end else begin
      reg_read_r <= bus.reg_read;
      datai      <= datai_next;
      rd_en      <= pop_hit & ~bus.fifo_empty;
      // A fresh underflow takes priority over a simultaneous clear.
      if (pop_hit & bus.fifo_empty)
        underflow <= 1'b1;
      else if (clear_req)
        underflow <= 1'b0;
      if (status_wr)
        mode <= bus.reg_datao[1];
    end
  end

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mode)
            state <= ARMED;
        end
        ARMED: begin
          if (!mode) begin
            state <= IDLE;
          end else if (fifo_sel && !bus.fifo_empty) begin
            state <= STREAM;
            fast  <= 1'b1;
          end
        end
        STREAM: begin
          // An empty FIFO does not end streaming; it only produces underflow.
          if (bus.reg_write || !mode || !fifo_sel) begin
            state <= IDLE;
            fast  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          fast  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_datai      = datai;
  assign bus.fast_fifo_read = fast;
  assign bus.fifo_rd_en     = rd_en;
  assign bus.fifo_underflow = underflow;
endmodule
